lms_weight_update_ctrl: RTL and testbench
=========================================

// Module: lms_weight_update_ctrl
// PURPOSE
//  Sequencer for the LMS weight-update step of the adaptive beamformer. On each start it
//  latches the current error sample e and step size mu. It then walks all array elements,
//  fetching x[k] from the sample buffer and presenting (x[k], e, mu) to one shared
//  e*x*mu update unit. The returned update is accumulated into weight w[k] with saturation.
//  One update unit is time-shared across all elements; the weight file lives here.
// PARAMETERS
//  NUM_ELEM  4   number of array elements / complex weights (>=2)
//  AW        2   address width, clog2(NUM_ELEM)
// PORTS
//  clk        in   1    system clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  cfg_mu_we  in   1    write strobe for mu shadow register
//  cfg_mu     in   18   unsigned step size (written when cfg_mu_we=1)
//  clr_w      in   1    clear all weights to 0 (honoured only in IDLE)
//  start      in   1    begin one update pass (honoured only in IDLE)
//  err_i/q    in   18   signed error sample, latched on accepted start
//  x_addr     out  AW   sample-buffer read address
//  x_i/x_q    in   18   signed sample, valid 1 cycle after x_addr is driven
//  upd_xi/xq  out  18   to update unit: registered x[k]
//  upd_ei/eq  out  18   to update unit: latched error
//  upd_mu     out  18   to update unit: mu latched at start
//  upd_i/q    in   18   signed update from unit (combinational, same cycle)
//  w_rd_addr  in   AW   weight read address (asynchronous read)
//  w_rd_i/q   out  18   signed weight w[w_rd_addr]
//  busy       out  1    high from accepted start until done
//  done       out  1    one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset: FSM=IDLE; k=0; mu_shadow=mu_act=0; err regs=0; x regs=0; all weights=0.
//   Outputs are then: x_addr=0, upd_*=0, busy=0, done=0, w_rd_*=0.
//   rst_n low mid-pass aborts immediately: no done pulse; weights return to 0.
//  mu: cfg_mu_we writes mu_shadow in any state. mu_act<=mu_shadow only on accepted start,
//   so a mid-pass write takes effect on the next pass.
//  FSM states: IDLE, FETCH, CAPT, ACCUM, DONE.
//   IDLE:  if start, latch err_i/q and mu_act, set k=0, go FETCH. Otherwise, if clr_w,
//          zero all weights. start has priority over clr_w in the same cycle.
//   FETCH: drive x_addr=k; go CAPT.
//   CAPT:  x_i/x_q are valid; register them into the upd_xi/xq regs; go ACCUM.
//   ACCUM: w[k] <= sat18(w[k] + upd); same for the Q component.
//          If k==NUM_ELEM-1, go DONE; else k<=k+1 and go FETCH.
//   DONE:  done=1 for one cycle; go IDLE.
//  x_addr holds k in FETCH, CAPT and ACCUM, and holds its last value otherwise.
//  busy=1 in FETCH, CAPT, ACCUM and DONE.
//  Latency: start accepted at edge 0 gives done high in cycle 3*NUM_ELEM+1; busy falls
//   together with done. A new start is accepted on the edge after done.
//  start/clr_w while busy: ignored, not queued.
//  Arithmetic: 19-bit signed sum, clamped to [-131072, +131071]; I and Q saturate
//   independently. The update unit's fixed-point format is passed through unchanged.
//  w_rd_* reflect a write on the cycle after the ACCUM edge; reads never stall the FSM.
// TESTING
//  1 Reset: rst_n=0 -> busy=0, done=0, x_addr=0; w_rd_i/q=0 for every address.
//  2 Pass, NUM_ELEM=4, stub upd=(100,-50): start -> x_addr 0,1,2,3; done in cycle 13;
//    all w=(100,-50). Second start -> all w=(200,-100).
//  3 Saturation: upd=(131071,-131072), run 2 passes -> all w=(131071,-131072), no wrap.
//  4 mu/err latching: cfg_mu=16 then start; write cfg_mu=32 mid-pass ->
//    upd_mu=16 for the whole pass and 32 on the next pass.
//    err changes mid-pass -> upd_ei/eq unchanged.
//  5 Ignored inputs: start and clr_w pulsed during busy -> single done, weights kept.
//    clr_w in IDLE -> all w=0.
//  6 Abort: rst_n low in cycle 5 of a pass -> busy=0 at once, no done, all w=0.
//    Start after release -> normal pass.

Source files
------------

// File: rtl/lms_weight_update_ctrl.sv
// LMS weight-update sequencer: walks every array element, feeds (x[k], e, mu)
// to one shared update unit and accumulates the returned update into the
// local weight file with 18-bit saturation on I and Q independently.
module lms_weight_update_ctrl #(
  parameter int NUM_ELEM = 4,
  parameter int AW       = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_mu_we,
  input  logic [17:0]   cfg_mu,
  input  logic          clr_w,
  input  logic          start,
  input  logic [17:0]   err_i,
  input  logic [17:0]   err_q,
  output logic [AW-1:0] x_addr,
  input  logic [17:0]   x_i,
  input  logic [17:0]   x_q,
  output logic [17:0]   upd_xi,
  output logic [17:0]   upd_xq,
  output logic [17:0]   upd_ei,
  output logic [17:0]   upd_eq,
  output logic [17:0]   upd_mu,
  input  logic [17:0]   upd_i,
  input  logic [17:0]   upd_q,
  input  logic [AW-1:0] w_rd_addr,
  output logic [17:0]   w_rd_i,
  output logic [17:0]   w_rd_q,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    ACCUM = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_ELEM - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] k;
  logic [17:0]   mu_shadow;
  logic [17:0]   mu_act;
  logic [17:0]   e_i_r;
  logic [17:0]   e_q_r;
  logic [17:0]   x_i_r;
  logic [17:0]   x_q_r;
  logic [17:0]   w_i [NUM_ELEM];
  logic [17:0]   w_q [NUM_ELEM];
  logic          start_acc;

  // Signed 18-bit add clamped to [-131072, 131071]; overflow shows as the
  // two top bits of the 19-bit sum disagreeing.
  function automatic logic [17:0] sat18(input logic [17:0] a, input logic [17:0] b);
    logic [18:0] s;
    s = {a[17], a} + {b[17], b};
    if (s[18] != s[17]) begin
      return s[18] ? 18'h20000 : 18'h1FFFF;
    end
    return s[17:0];
  endfunction

  assign start_acc = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: state_nxt = CAPT;
      CAPT:  state_nxt = ACCUM;
      ACCUM: state_nxt = (k == LAST) ? DONE : FETCH;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // mu shadow is writable at any time; it only reaches the unit on a start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         mu_shadow <= '0;
    else if (cfg_mu_we) mu_shadow <= cfg_mu;
  end

  // Per-pass operands and element index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      mu_act <= '0;
      e_i_r  <= '0;
      e_q_r  <= '0;
      x_i_r  <= '0;
      x_q_r  <= '0;
    end else begin
      if (start_acc) begin
        k      <= '0;
        mu_act <= mu_shadow;
        e_i_r  <= err_i;
        e_q_r  <= err_q;
      end
      if (state == CAPT) begin
        x_i_r <= x_i;
        x_q_r <= x_q;
      end
      if (state == ACCUM && k != LAST) k <= k + 1'b1;
    end
  end

  // Weight file: clear in IDLE (start wins), saturating accumulate in ACCUM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_ELEM; j++) begin
        w_i[j] <= '0;
        w_q[j] <= '0;
      end
    end else if (state == IDLE && clr_w && !start) begin
      for (int j = 0; j < NUM_ELEM; j++) begin
        w_i[j] <= '0;
        w_q[j] <= '0;
      end
    end else if (state == ACCUM) begin
      w_i[k] <= sat18(w_i[k], upd_i);
      w_q[k] <= sat18(w_q[k], upd_q);
    end
  end

  // k is only reloaded on start and stays put after the last element,
  // so it is exactly the address the sample buffer should see.
  assign x_addr = k;
  assign upd_xi = x_i_r;
  assign upd_xq = x_q_r;
  assign upd_ei = e_i_r;
  assign upd_eq = e_q_r;
  assign upd_mu = mu_act;
  assign w_rd_i = w_i[w_rd_addr];
  assign w_rd_q = w_q[w_rd_addr];

endmodule

// File: tb/tb_lms_weight_update_ctrl.sv
// Testbench for lms_weight_update_ctrl: stimulus pushes one expected record
// per pass onto a scoreboard; a negedge monitor pops it when done appears.
// Weights are checked against a behavioural model of the whole pass.
module tb_lms_weight_update_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_mu_we;
  logic [17:0]   cfg_mu;
  logic          clr_w;
  logic          start;
  logic [17:0]   err_i;
  logic [17:0]   err_q;
  logic [AW-1:0] x_addr;
  logic [17:0]   x_i;
  logic [17:0]   x_q;
  logic [17:0]   upd_xi;
  logic [17:0]   upd_xq;
  logic [17:0]   upd_ei;
  logic [17:0]   upd_eq;
  logic [17:0]   upd_mu;
  logic [17:0]   upd_i;
  logic [17:0]   upd_q;
  logic [AW-1:0] w_rd_addr;
  logic [17:0]   w_rd_i;
  logic [17:0]   w_rd_q;
  logic          busy;
  logic          done;

  typedef struct {
    int          c0;
    int          done_cyc;
    logic [17:0] mu;
    logic [17:0] ei;
    logic [17:0] eq;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pass_bad = 0;
  int          upd_mode = 0;
  logic [17:0] stub_i = '0;
  logic [17:0] stub_q = '0;
  logic [17:0] xi_mem [N];
  logic [17:0] xq_mem [N];
  logic [17:0] mu_m = '0;
  int          wi_m [N];
  int          wq_m [N];

  lms_weight_update_ctrl #(.NUM_ELEM(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mu_we(cfg_mu_we), .cfg_mu(cfg_mu),
    .clr_w(clr_w), .start(start), .err_i(err_i), .err_q(err_q),
    .x_addr(x_addr), .x_i(x_i), .x_q(x_q),
    .upd_xi(upd_xi), .upd_xq(upd_xq), .upd_ei(upd_ei), .upd_eq(upd_eq),
    .upd_mu(upd_mu), .upd_i(upd_i), .upd_q(upd_q),
    .w_rd_addr(w_rd_addr), .w_rd_i(w_rd_i), .w_rd_q(w_rd_q),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample buffer with one cycle of read latency
  always @(posedge clk) begin
    x_i <= xi_mem[int'(x_addr)];
    x_q <= xq_mem[int'(x_addr)];
  end

  // Update-unit stand-in: fixed stub or a mix of all three operands
  always_comb begin
    if (upd_mode == 0) begin
      upd_i = stub_i;
      upd_q = stub_q;
    end else begin
      upd_i = upd_xi + upd_ei + upd_mu;
      upd_q = upd_xq - upd_eq + (upd_mu >> 1);
    end
  end

  function automatic int s18(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp(input int v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkWeights(input string tag);
    for (int a = 0; a < N; a++) begin
      w_rd_addr = AW'(a);
      #1;
      checkOutput($sformatf("%s_w_i[%0d]", tag, a), s18(w_rd_i), wi_m[a]);
      checkOutput($sformatf("%s_w_q[%0d]", tag, a), s18(w_rd_q), wq_m[a]);
    end
  endtask

  task automatic writeMu(input logic [17:0] v);
    @(negedge clk);
    cfg_mu    = v;
    cfg_mu_we = 1'b1;
    @(negedge clk);
    cfg_mu_we = 1'b0;
    mu_m      = v;
  endtask

  task automatic clrIdle();
    @(negedge clk);
    clr_w = 1'b1;
    @(negedge clk);
    clr_w = 1'b0;
    for (int k = 0; k < N; k++) begin
      wi_m[k] = 0;
      wq_m[k] = 0;
    end
    checkWeights("clr");
  endtask

  // One full pass; optional mid-pass mu write, ignored start/clr pulses,
  // or clr_w raised together with start.
  task automatic applyStimulus(input bit mid_mu, input bit mid_pulse, input bit with_clr);
    rec_t        r;
    logic [17:0] ui;
    logic [17:0] uq;
    int          n;
    bit          seen;
    @(negedge clk);
    err_i = 18'($urandom);
    err_q = 18'($urandom);
    start = 1'b1;
    clr_w = with_clr;
    r.mu = mu_m;
    r.ei = err_i;
    r.eq = err_q;
    for (int k = 0; k < N; k++) begin
      if (upd_mode == 0) begin
        ui = stub_i;
        uq = stub_q;
      end else begin
        ui = xi_mem[k] + r.ei + r.mu;
        uq = xq_mem[k] - r.eq + (r.mu >> 1);
      end
      wi_m[k] = clamp(wi_m[k] + s18(ui));
      wq_m[k] = clamp(wq_m[k] + s18(uq));
    end
    @(posedge clk);
    #1;
    r.c0       = cyc;
    r.done_cyc = cyc + 3 * N;
    sb.push_back(r);
    @(negedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * N + 8) begin
      start     = 1'b0;
      clr_w     = 1'b0;
      cfg_mu_we = 1'b0;
      err_i     = 18'($urandom);
      err_q     = 18'($urandom);
      if (done) seen = 1'b1;
      if (mid_mu && n == 4) begin
        cfg_mu    = 18'd32;
        cfg_mu_we = 1'b1;
        mu_m      = 18'd32;
      end
      if (mid_pulse && (n == 4 || seen)) begin
        start = 1'b1;
        clr_w = 1'b1;
      end
      if (!seen) begin
        @(negedge clk);
        n++;
      end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    @(negedge clk);
    start     = 1'b0;
    clr_w     = 1'b0;
    cfg_mu_we = 1'b0;
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("done_one_cycle", int'(done), 0);
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);
    checkWeights("pass");
  endtask

  // Reset asserted in cycle 5 of a pass that is never scoreboarded
  task automatic doAbort();
    @(negedge clk);
    err_i = 18'($urandom);
    err_q = 18'($urandom);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_x_addr", int'(x_addr), 0);
    for (int k = 0; k < N; k++) begin
      wi_m[k] = 0;
      wq_m[k] = 0;
    end
    mu_m = '0;
    checkWeights("abort");
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", int'(done), 0);
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle address/operand tracking, scoreboard pop on done
  always @(negedge clk) begin
    rec_t r;
    if (rst_n) begin
      if (busy && !done && sb.size() > 0) begin
        if (int'(x_addr) != (cyc - sb[0].c0) / 3) pass_bad++;
        if (upd_mu != sb[0].mu || upd_ei != sb[0].ei || upd_eq != sb[0].eq) pass_bad++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          r = sb.pop_front();
          checkOutput("done_cycle", cyc - r.c0, r.done_cyc - r.c0);
          checkOutput("busy_with_done", int'(busy), 1);
          checkOutput("pass_addr_operands", pass_bad, 0);
          checkOutput("upd_mu", int'(upd_mu), int'(r.mu));
          checkOutput("upd_ei", int'(upd_ei), int'(r.ei));
          checkOutput("upd_eq", int'(upd_eq), int'(r.eq));
        end
        pass_bad = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    cfg_mu_we = 1'b0;
    cfg_mu    = '0;
    clr_w     = 1'b0;
    start     = 1'b0;
    err_i     = '0;
    err_q     = '0;
    w_rd_addr = '0;
    for (int k = 0; k < N; k++) begin
      xi_mem[k] = '0;
      xq_mem[k] = '0;
      wi_m[k]   = 0;
      wq_m[k]   = 0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_x_addr", int'(x_addr), 0);
    checkOutput("reset_upd_mu", int'(upd_mu), 0);
    checkOutput("reset_upd_ei", int'(upd_ei), 0);
    checkOutput("reset_upd_xi", int'(upd_xi), 0);
    checkWeights("reset");
    @(negedge clk);
    rst_n = 1'b1;

    upd_mode = 0;
    stub_i   = 18'(100);
    stub_q   = 18'(-50);
    writeMu(18'd16);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    clrIdle();

    stub_i = 18'(131071);
    stub_q = 18'(-131072);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    clrIdle();

    upd_mode = 1;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < N; k++) begin
        xi_mem[k] = 18'($urandom);
        xq_mem[k] = 18'($urandom);
      end
      if ($urandom_range(0, 1) == 1) writeMu(18'($urandom));
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));
    end

    doAbort();
    writeMu(18'd5);
    applyStimulus(1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
